uart_rx_fifo: RTL and testbench

Receive buffer that sits directly downstream of the UART receiver. It captures each completed character on the receiver's one-cycle valid pulse, together with its parity-error flag, into a circular FIFO. Characters are handed to the bus side through a pop/read handshake. It also reports fill level, a sticky overrun flag and a level interrupt, so the core can drain received data in bursts instead of per character.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo_mem.sv | 39 +++
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, the receive-entry layout and the FIFO pointer-width helper.
// The optional parity field follows UART_RX_FIFO_PARITY_EN.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DEPTH     = 16;

`ifdef UART_RX_FIFO_PARITY_EN
    localparam int UART_PAR_W = 1;
`else
    localparam int UART_PAR_W = 0;
`endif

    typedef struct packed {
`ifdef UART_RX_FIFO_PARITY_EN
        logic                      parity_err;
`endif
        logic [UART_DATA_BITS-1:0] data;
    } uart_rx_entry_t;

    function automatic int uart_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Depth x width register array: one synchronous write port, one registered read port.
// Read data updates only when re_i is high and otherwise holds; the array is not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = UART_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic [uart_ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         re_i,
    input  logic [uart_ptr_w(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]             rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reading the old word on a same-address write is what lets a full FIFO push and pop together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures rx_data_vld pulses, pops give rd_data/rd_vld one cycle after rd_en.
// Full without a pop drops the character and sets sticky overrun; UART_RX_FIFO_PARITY_EN stores parity.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int data_bits = UART_DATA_BITS,
    parameter int depth     = UART_DEPTH,
    parameter int irq_level = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [data_bits-1:0]       rx_data_in,
    input  logic                       rx_data_vld,
    input  logic                       rx_parity_err,
    input  logic                       rd_en,
    input  logic                       flush,
    input  logic                       overrun_clr,
    output logic [data_bits-1:0]       rd_data,
    output logic                       rd_parity_err,
    output logic                       rd_vld,
    output logic [$clog2(depth):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overrun,
    output logic                       irq
);

    localparam int PW      = uart_ptr_w(depth);
    localparam int CW      = $clog2(depth) + 1;
    localparam int ENTRY_W = data_bits + UART_PAR_W;

    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               rd_vld_q;
    logic               empty_w, full_w;
    logic               pop, push, drop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(depth));

    // A pop frees the slot the write lands in, so full + pop still accepts the character.
    assign pop  = rd_en && !empty_w && !flush;
    assign push = rx_data_vld && (!full_w || pop) && !flush;
    assign drop = rx_data_vld && full_w && !pop && !flush;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rd_vld_q  <= pop;
        end
    end

`ifdef UART_RX_FIFO_PARITY_EN
    assign wr_entry      = {rx_parity_err, rx_data_in};
    assign rd_data       = rd_entry[data_bits-1:0];
    assign rd_parity_err = rd_entry[data_bits];
`else
    logic unused_parity;
    assign unused_parity = rx_parity_err;
    assign wr_entry      = rx_data_in;
    assign rd_data       = rd_entry;
    assign rd_parity_err = 1'b0;
`endif

    uart_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (depth)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .re_i    (pop),
        .raddr_i (rptr_q),
        .rdata_o (rd_entry)
    );

    assign count   = count_q;
    assign empty   = empty_w;
    assign full    = full_w;
    assign overrun = overrun_q;
    assign rd_vld  = rd_vld_q;
    assign irq     = (count_q >= CW'(irq_level)) | overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo (depth 16, irq_level 8); parity expectations follow UART_RX_FIFO_PARITY_EN.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data_in;
    logic       rx_data_vld;
    logic       rx_parity_err;
    logic       rd_en;
    logic       flush;
    logic       overrun_clr;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       rd_vld;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    // Expected pops: {parity, data}
    logic [8:0] exp_q [$];

    uart_rx_fifo #(
        .data_bits (8),
        .depth     (16),
        .irq_level (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_in    (rx_data_in),
        .rx_data_vld   (rx_data_vld),
        .rx_parity_err (rx_parity_err),
        .rd_en         (rd_en),
        .flush         (flush),
        .overrun_clr   (overrun_clr),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_vld        (rd_vld),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overrun       (overrun),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every rd_vld pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rd_vld: got data 0x%0h expected no pop", rd_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({rd_parity_err, rd_data} !== e) begin
                    failures++;
                    $display("FAIL pop_data: got par=%0b data=0x%0h expected par=%0b data=0x%0h",
                             rd_parity_err, rd_data, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_par(input logic p);
`ifdef UART_RX_FIFO_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input logic [7:0] d, input logic p, input bit stored);
        rx_data_in    = d;
        rx_parity_err = p;
        rx_data_vld   = 1'b1;
        if (stored) exp_q.push_back({exp_par(p), d});
        cycle();
        rx_data_vld   = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) cycle();
        rd_en = 1'b0;
        repeat (3) cycle();
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_rd_vld"}, rd_vld, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_par"}, rd_parity_err, 0);
    endtask

    initial begin
        rst = 1'b1; rx_data_in = '0; rx_data_vld = 1'b0; rx_parity_err = 1'b0;
        rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
        repeat (3) cycle();
        check_reset_state("reset");
        rst = 1'b0;
        cycle();

        // Spaced pushes, then back-to-back pops
        for (int i = 0; i < 3; i++) begin
            push(8'h41 + 8'(i), 1'b0, 1'b1);
            if (i == 0) check("write_latency_count", count, 1);
            repeat (9) cycle();
        end
        check("three_count", count, 3);
        drain(3);
        check("after_drain_count", count, 0);
        check("after_drain_empty", empty, 1);

        // Parity propagation (forced to 0 without the parity build)
        push(8'h33, 1'b1, 1'b1);
        push(8'h34, 1'b0, 1'b1);
        drain(2);

        // Overfill: 0x10 is dropped
        for (int i = 0; i < 17; i++) push(8'(i), 1'b0, i < 16);
        check("overfill_full", full, 1);
        check("overfill_count", count, 16);
        check("overfill_overrun", overrun, 1);
        check("overfill_irq", irq, 1);
        drain(16);
        check("overrun_sticky", overrun, 1);
        check("overrun_irq_when_empty", irq, 1);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);
        check("irq_cleared", irq, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1'b0, 1'b1);
        rd_en = 1'b1;
        push(8'h55, 1'b0, 1'b1);
        rd_en = 1'b0;
        check("full_pushpop_count", count, 16);
        check("full_pushpop_overrun", overrun, 0);
        drain(16);

        // Empty with simultaneous push and pop: pop ignored
        rd_en = 1'b1;
        push(8'h7E, 1'b0, 1'b0);
        rd_en = 1'b0;
        check("empty_pushpop_no_vld", rd_vld, 0);
        check("empty_pushpop_count", count, 1);
        exp_q.push_back({1'b0, 8'h7E});
        drain(1);

        // irq threshold
        for (int i = 1; i <= 7; i++) push(8'(i), 1'b0, 1'b1);
        check("irq_below_level", irq, 0);
        push(8'h08, 1'b0, 1'b1);
        check("irq_at_level", irq, 1);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("irq_after_pop", irq, 0);
        drain(7);

        // Flush with concurrent write and pop; rd_data keeps last pop (0x08)
        for (int i = 0; i < 5; i++) push(8'h21 + 8'(i), 1'b0, 1'b0);
        check("preflush_count", count, 5);
        flush = 1'b1; rd_en = 1'b1;
        push(8'hEE, 1'b0, 1'b0);
        flush = 1'b0; rd_en = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_rd_data", rd_data, 8'h08);
        check("flush_no_vld", rd_vld, 0);
        push(8'h99, 1'b0, 1'b1);
        drain(1);

        // Reset mid-stream during a write and pop
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b0, 1'b0);
        rd_en = 1'b1; rx_data_vld = 1'b1; rx_data_in = 8'hDD;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        rd_en = 1'b0; rx_data_vld = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        check("postrst_count", count, 0);
        push(8'hA5, 1'b0, 1'b1);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
